// File: rtl/spatz_id_scheduler.sv
// spatz_id_scheduler: allocates/retires vector instruction IDs, tracks per-ID owner, idle and sticky flags
// Ports:
//   clk_i, rst_ni                       clock, asynchronous active-low reset
//   alloc_valid_i/ready_o/ex_unit_i/id_o allocation handshake (ex_unit: 0=CON 1=LSU 2=SLD 3=VFU)
//   vfu/vlsu/vsldu_rsp_valid_i/id_i     per-unit retirement, vlsu_rsp_exc_i flags a memory exception
//   busy_o, unit_idle_o {VSLDU,VLSU,VFU}, all_idle_o   occupancy status
//   exc_o, err_o, flag_clear_i          sticky exception / protocol-error flags and their clear
//   oldest_valid_o, oldest_id_o         oldest in-flight ID (SPATZ_ID_SCHED_AGE_TRACK_EN), else tied 0
module spatz_id_scheduler #(
    parameter int unsigned NrIds   = 4,
    parameter int unsigned IdWidth = $clog2(NrIds)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               alloc_valid_i,
    output logic               alloc_ready_o,
    input  logic [1:0]         alloc_ex_unit_i,
    output logic [IdWidth-1:0] alloc_id_o,
    input  logic               vfu_rsp_valid_i,
    input  logic [IdWidth-1:0] vfu_rsp_id_i,
    input  logic               vlsu_rsp_valid_i,
    input  logic [IdWidth-1:0] vlsu_rsp_id_i,
    input  logic               vlsu_rsp_exc_i,
    input  logic               vsldu_rsp_valid_i,
    input  logic [IdWidth-1:0] vsldu_rsp_id_i,
    output logic [NrIds-1:0]   busy_o,
    output logic [2:0]         unit_idle_o,
    output logic               all_idle_o,
    output logic               exc_o,
    output logic               err_o,
    input  logic               flag_clear_i,
    output logic               oldest_valid_o,
    output logic [IdWidth-1:0] oldest_id_o
);
    localparam logic [1:0] Con = 2'd0, Lsu = 2'd1, Sld = 2'd2, Vfu = 2'd3;

    logic [NrIds-1:0]        busy_q, busy_d, ret_mask;
    logic [NrIds-1:0][1:0]   owner_q, owner_d;
    logic                    exc_q, exc_d, err_q, err_d, err_set;
    logic [IdWidth-1:0]      free_id;
    logic                    is_con, full, grant;
    logic [2:0]              rsp_v;
    logic [2:0][IdWidth-1:0] rsp_id;
    logic [2:0][1:0]         rsp_unit;

    assign rsp_v    = {vsldu_rsp_valid_i, vlsu_rsp_valid_i, vfu_rsp_valid_i};
    assign rsp_id   = {vsldu_rsp_id_i, vlsu_rsp_id_i, vfu_rsp_id_i};
    assign rsp_unit = {Sld, Lsu, Vfu};

    // CON instructions complete in the controller: always accepted, never occupy an ID
    assign is_con        = alloc_ex_unit_i == Con;
    assign full          = &busy_q;
    assign grant         = alloc_valid_i & ~is_con & ~full;
    assign alloc_ready_o = is_con | ~full;
    assign alloc_id_o    = is_con ? '0 : free_id;
    assign busy_o        = busy_q;
    assign all_idle_o    = ~|busy_q;
    assign exc_o         = exc_q;
    assign err_o         = err_q;

    always_comb begin
        free_id = '0;
        for (int i = NrIds - 1; i >= 0; i--)
            if (!busy_q[i]) free_id = IdWidth'(i);
    end

    // only a response from the owning unit to a busy ID retires; everything else is a protocol error
    always_comb begin
        ret_mask = '0;
        err_set  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (rsp_v[k]) begin
                if (busy_q[rsp_id[k]] && owner_q[rsp_id[k]] == rsp_unit[k]) ret_mask[rsp_id[k]] = 1'b1;
                else err_set = 1'b1;
            end
            for (int m = k + 1; m < 3; m++)
                if (rsp_v[k] && rsp_v[m] && rsp_id[k] == rsp_id[m]) err_set = 1'b1;
        end
    end

    // the granted ID is free in busy_q, so it can never collide with a retiring one
    always_comb begin
        busy_d  = busy_q & ~ret_mask;
        owner_d = owner_q;
        if (grant) begin
            busy_d[free_id]  = 1'b1;
            owner_d[free_id] = alloc_ex_unit_i;
        end
    end

    assign exc_d = (vlsu_rsp_valid_i & vlsu_rsp_exc_i) | (exc_q & ~flag_clear_i);
    assign err_d = err_set | (err_q & ~flag_clear_i);

    always_comb begin
        unit_idle_o = 3'b111;
        for (int i = 0; i < NrIds; i++) begin
            if (busy_q[i] && owner_q[i] == Vfu) unit_idle_o[0] = 1'b0;
            if (busy_q[i] && owner_q[i] == Lsu) unit_idle_o[1] = 1'b0;
            if (busy_q[i] && owner_q[i] == Sld) unit_idle_o[2] = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q  <= '0;
            owner_q <= '0;
            exc_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            owner_q <= owner_d;
            exc_q   <= exc_d;
            err_q   <= err_d;
        end
    end

`ifdef SPATZ_ID_SCHED_AGE_TRACK_EN
    // age_q[j][i] set: ID j is older than ID i
    logic [NrIds-1:0][NrIds-1:0] age_q, age_d;
    logic                        blk;

    always_comb begin
        age_d = age_q;
        for (int i = 0; i < NrIds; i++) begin
            if (ret_mask[i]) begin
                age_d[i] = '0;
                for (int j = 0; j < NrIds; j++) age_d[j][i] = 1'b0;
            end
        end
        if (grant) begin
            age_d[free_id] = '0;
            for (int j = 0; j < NrIds; j++) age_d[j][free_id] = busy_q[j] & ~ret_mask[j];
        end
    end

    // oldest is the busy ID with no busy ID older than it
    always_comb begin
        oldest_id_o = '0;
        blk         = 1'b0;
        for (int i = NrIds - 1; i >= 0; i--) begin
            blk = 1'b0;
            for (int j = 0; j < NrIds; j++) blk = blk | (busy_q[j] & age_q[j][i]);
            if (busy_q[i] && !blk) oldest_id_o = IdWidth'(i);
        end
    end

    assign oldest_valid_o = |busy_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) age_q <= '0;
        else age_q <= age_d;
    end
`else
    assign oldest_valid_o = 1'b0;
    assign oldest_id_o    = '0;
`endif
endmodule

// File: tb/tb_spatz_id_scheduler.sv
// tb_spatz_id_scheduler: directed self-checking bench for spatz_id_scheduler
module tb_spatz_id_scheduler;
    localparam logic [1:0] CON = 2'd0, LSU = 2'd1, SLD = 2'd2, VFU = 2'd3;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       alloc_valid_i, alloc_ready_o;
    logic [1:0] alloc_ex_unit_i, alloc_id_o;
    logic       vfu_rsp_valid_i, vlsu_rsp_valid_i, vlsu_rsp_exc_i, vsldu_rsp_valid_i;
    logic [1:0] vfu_rsp_id_i, vlsu_rsp_id_i, vsldu_rsp_id_i;
    logic [3:0] busy_o;
    logic [2:0] unit_idle_o;
    logic       all_idle_o, exc_o, err_o, flag_clear_i, oldest_valid_o;
    logic [1:0] oldest_id_o;
    int         total = 0;
    int         bad = 0;

    spatz_id_scheduler #(.NrIds(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o),
        .alloc_ex_unit_i(alloc_ex_unit_i), .alloc_id_o(alloc_id_o),
        .vfu_rsp_valid_i(vfu_rsp_valid_i), .vfu_rsp_id_i(vfu_rsp_id_i),
        .vlsu_rsp_valid_i(vlsu_rsp_valid_i), .vlsu_rsp_id_i(vlsu_rsp_id_i), .vlsu_rsp_exc_i(vlsu_rsp_exc_i),
        .vsldu_rsp_valid_i(vsldu_rsp_valid_i), .vsldu_rsp_id_i(vsldu_rsp_id_i),
        .busy_o(busy_o), .unit_idle_o(unit_idle_o), .all_idle_o(all_idle_o),
        .exc_o(exc_o), .err_o(err_o), .flag_clear_i(flag_clear_i),
        .oldest_valid_o(oldest_valid_o), .oldest_id_o(oldest_id_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step;
        @(posedge clk_i);
        #1;
    endtask

    task automatic clr_in;
        alloc_valid_i = 1'b0; alloc_ex_unit_i = CON; flag_clear_i = 1'b0;
        vfu_rsp_valid_i = 1'b0; vfu_rsp_id_i = 2'd0;
        vlsu_rsp_valid_i = 1'b0; vlsu_rsp_id_i = 2'd0; vlsu_rsp_exc_i = 1'b0;
        vsldu_rsp_valid_i = 1'b0; vsldu_rsp_id_i = 2'd0;
    endtask

    task automatic do_reset;
        clr_in();
        rst_ni = 1'b0;
        step();
        step();
        rst_ni = 1'b1;
        step();
    endtask

    task automatic alloc(input logic [1:0] u);
        alloc_valid_i = 1'b1; alloc_ex_unit_i = u;
        step();
        alloc_valid_i = 1'b0; alloc_ex_unit_i = CON;
    endtask

    task automatic test_reset;
        clr_in();
        alloc_ex_unit_i = VFU;
        rst_ni = 1'b0;
        step();
        step();
        total++; if (alloc_ready_o !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", alloc_ready_o); end
        total++; if (alloc_id_o !== 2'd0) begin bad++; $display("FAIL rst_id got=%0d exp=0", alloc_id_o); end
        total++; if (busy_o !== 4'b0000) begin bad++; $display("FAIL rst_busy got=%b exp=0000", busy_o); end
        total++; if (unit_idle_o !== 3'b111) begin bad++; $display("FAIL rst_unit_idle got=%b exp=111", unit_idle_o); end
        total++; if (all_idle_o !== 1'b1) begin bad++; $display("FAIL rst_all_idle got=%b exp=1", all_idle_o); end
        total++; if ({exc_o, err_o} !== 2'b00) begin bad++; $display("FAIL rst_flags got=%b exp=00", {exc_o, err_o}); end
        total++; if ({oldest_valid_o, oldest_id_o} !== 3'b000) begin bad++; $display("FAIL rst_oldest got=%b exp=000", {oldest_valid_o, oldest_id_o}); end
        rst_ni = 1'b1;
        step();
    endtask

    task automatic test_fill;
        do_reset();
        alloc_valid_i = 1'b1; alloc_ex_unit_i = VFU;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++; if (alloc_ready_o !== 1'b1 || alloc_id_o !== 2'(i)) begin bad++; $display("FAIL fill_grant%0d got=%b/%0d exp=1/%0d", i, alloc_ready_o, alloc_id_o, i); end
            step();
        end
        total++; if (alloc_ready_o !== 1'b0) begin bad++; $display("FAIL fill_ready got=%b exp=0", alloc_ready_o); end
        total++; if (busy_o !== 4'b1111) begin bad++; $display("FAIL fill_busy got=%b exp=1111", busy_o); end
        total++; if (unit_idle_o !== 3'b110) begin bad++; $display("FAIL fill_unit_idle got=%b exp=110", unit_idle_o); end
        total++; if (all_idle_o !== 1'b0) begin bad++; $display("FAIL fill_all_idle got=%b exp=0", all_idle_o); end
        step();
        total++; if (busy_o !== 4'b1111 || alloc_ready_o !== 1'b0) begin bad++; $display("FAIL fill_hold got=%b/%b exp=1111/0", busy_o, alloc_ready_o); end
        clr_in();
    endtask

    task automatic test_retire_while_full;
        do_reset();
        alloc(VFU); alloc(VFU); alloc(LSU); alloc(VFU);
        total++; if (unit_idle_o !== 3'b100) begin bad++; $display("FAIL rwf_unit_idle got=%b exp=100", unit_idle_o); end
        alloc_valid_i = 1'b1; alloc_ex_unit_i = VFU;
        vlsu_rsp_valid_i = 1'b1; vlsu_rsp_id_i = 2'd2;
        #1;
        total++; if (alloc_ready_o !== 1'b0) begin bad++; $display("FAIL rwf_same_cycle_ready got=%b exp=0", alloc_ready_o); end
        step();
        vlsu_rsp_valid_i = 1'b0;
        #1;
        total++; if (alloc_ready_o !== 1'b1 || alloc_id_o !== 2'd2) begin bad++; $display("FAIL rwf_regrant got=%b/%0d exp=1/2", alloc_ready_o, alloc_id_o); end
        total++; if (busy_o !== 4'b1011) begin bad++; $display("FAIL rwf_busy got=%b exp=1011", busy_o); end
        step();
        clr_in();
        total++; if (busy_o !== 4'b1111 || err_o !== 1'b0) begin bad++; $display("FAIL rwf_refill got=%b/%b exp=1111/0", busy_o, err_o); end
    endtask

    task automatic test_triple_retire;
        do_reset();
        alloc(VFU); alloc(LSU); alloc(SLD);
        total++; if (busy_o !== 4'b0111 || unit_idle_o !== 3'b000) begin bad++; $display("FAIL tri_setup got=%b/%b exp=0111/000", busy_o, unit_idle_o); end
        vfu_rsp_valid_i = 1'b1; vfu_rsp_id_i = 2'd0;
        vlsu_rsp_valid_i = 1'b1; vlsu_rsp_id_i = 2'd1;
        vsldu_rsp_valid_i = 1'b1; vsldu_rsp_id_i = 2'd2;
        step();
        clr_in();
        total++; if (busy_o !== 4'b0000 || all_idle_o !== 1'b1) begin bad++; $display("FAIL tri_busy got=%b/%b exp=0000/1", busy_o, all_idle_o); end
        total++; if (err_o !== 1'b0 || unit_idle_o !== 3'b111) begin bad++; $display("FAIL tri_err_idle got=%b/%b exp=0/111", err_o, unit_idle_o); end
    endtask

    task automatic test_errors;
        do_reset();
        alloc(VFU); alloc(LSU);
        vsldu_rsp_valid_i = 1'b1; vsldu_rsp_id_i = 2'd1;
        step();
        clr_in();
        total++; if (err_o !== 1'b1 || busy_o !== 4'b0011) begin bad++; $display("FAIL err_owner got=%b/%b exp=1/0011", err_o, busy_o); end
        flag_clear_i = 1'b1;
        step();
        clr_in();
        total++; if (err_o !== 1'b0) begin bad++; $display("FAIL err_clear got=%b exp=0", err_o); end
        flag_clear_i = 1'b1; vfu_rsp_valid_i = 1'b1; vfu_rsp_id_i = 2'd3;
        step();
        clr_in();
        total++; if (err_o !== 1'b1 || busy_o !== 4'b0011) begin bad++; $display("FAIL err_set_wins got=%b/%b exp=1/0011", err_o, busy_o); end
        flag_clear_i = 1'b1;
        step();
        clr_in();
        vfu_rsp_valid_i = 1'b1; vfu_rsp_id_i = 2'd0;
        vlsu_rsp_valid_i = 1'b1; vlsu_rsp_id_i = 2'd0;
        step();
        clr_in();
        total++; if (err_o !== 1'b1 || busy_o !== 4'b0010) begin bad++; $display("FAIL err_dup got=%b/%b exp=1/0010", err_o, busy_o); end
        total++; if (exc_o !== 1'b0) begin bad++; $display("FAIL err_no_exc got=%b exp=0", exc_o); end
    endtask

    task automatic test_exc_con;
        do_reset();
        alloc(VFU); alloc(LSU);
        vlsu_rsp_valid_i = 1'b1; vlsu_rsp_id_i = 2'd1; vlsu_rsp_exc_i = 1'b1;
        step();
        clr_in();
        total++; if (exc_o !== 1'b1 || busy_o !== 4'b0001 || err_o !== 1'b0) begin bad++; $display("FAIL exc_set got=%b/%b/%b exp=1/0001/0", exc_o, busy_o, err_o); end
        step();
        total++; if (exc_o !== 1'b1) begin bad++; $display("FAIL exc_sticky got=%b exp=1", exc_o); end
        alloc(VFU); alloc(VFU); alloc(VFU);
        alloc_valid_i = 1'b1; alloc_ex_unit_i = CON;
        #1;
        total++; if (alloc_ready_o !== 1'b1 || alloc_id_o !== 2'd0) begin bad++; $display("FAIL con_full got=%b/%0d exp=1/0", alloc_ready_o, alloc_id_o); end
        step();
        clr_in();
        total++; if (busy_o !== 4'b1111 || unit_idle_o !== 3'b110) begin bad++; $display("FAIL con_nochange got=%b/%b exp=1111/110", busy_o, unit_idle_o); end
        flag_clear_i = 1'b1;
        step();
        clr_in();
        total++; if (exc_o !== 1'b0) begin bad++; $display("FAIL exc_clear got=%b exp=0", exc_o); end
    endtask

    task automatic test_age;
        do_reset();
        alloc(VFU); alloc(VFU); alloc(VFU);
`ifdef SPATZ_ID_SCHED_AGE_TRACK_EN
        total++; if (oldest_valid_o !== 1'b1 || oldest_id_o !== 2'd0) begin bad++; $display("FAIL age_first got=%b/%0d exp=1/0", oldest_valid_o, oldest_id_o); end
        vfu_rsp_valid_i = 1'b1; vfu_rsp_id_i = 2'd0;
        step();
        clr_in();
        total++; if (oldest_id_o !== 2'd1) begin bad++; $display("FAIL age_retire0 got=%0d exp=1", oldest_id_o); end
        alloc_valid_i = 1'b1; alloc_ex_unit_i = VFU;
        #1;
        total++; if (alloc_id_o !== 2'd0) begin bad++; $display("FAIL age_regrant got=%0d exp=0", alloc_id_o); end
        step();
        clr_in();
        total++; if (oldest_id_o !== 2'd1 || busy_o !== 4'b0111) begin bad++; $display("FAIL age_still1 got=%0d/%b exp=1/0111", oldest_id_o, busy_o); end
        alloc_valid_i = 1'b1; alloc_ex_unit_i = VFU;
        vfu_rsp_valid_i = 1'b1; vfu_rsp_id_i = 2'd1;
        step();
        clr_in();
        total++; if (oldest_id_o !== 2'd2 || busy_o !== 4'b1101) begin bad++; $display("FAIL age_simul got=%0d/%b exp=2/1101", oldest_id_o, busy_o); end
`else
        total++; if (oldest_valid_o !== 1'b0 || oldest_id_o !== 2'd0) begin bad++; $display("FAIL age_tied got=%b/%0d exp=0/0", oldest_valid_o, oldest_id_o); end
`endif
    endtask

    task automatic test_async_reset;
        do_reset();
        alloc(VFU); alloc(LSU);
        total++; if (busy_o !== 4'b0011) begin bad++; $display("FAIL arst_setup got=%b exp=0011", busy_o); end
        rst_ni = 1'b0;
        #1;
        total++; if (busy_o !== 4'b0000 || all_idle_o !== 1'b1) begin bad++; $display("FAIL arst_immediate got=%b/%b exp=0000/1", busy_o, all_idle_o); end
        vfu_rsp_valid_i = 1'b1; vfu_rsp_id_i = 2'd2;
        step();
        total++; if (err_o !== 1'b0 || busy_o !== 4'b0000) begin bad++; $display("FAIL arst_rsp_ignored got=%b/%b exp=0/0000", err_o, busy_o); end
        clr_in();
        rst_ni = 1'b1;
        alloc_ex_unit_i = SLD;
        #1;
        total++; if (alloc_ready_o !== 1'b1 || alloc_id_o !== 2'd0 || unit_idle_o !== 3'b111) begin bad++; $display("FAIL arst_release got=%b/%0d/%b exp=1/0/111", alloc_ready_o, alloc_id_o, unit_idle_o); end
        clr_in();
    endtask

    initial begin
        test_reset();
        test_fill();
        test_retire_while_full();
        test_triple_retire();
        test_errors();
        test_exc_con();
        test_age();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
